usb_cdc_chan_mux: RTL and testbench

Multi-channel byte-stream multiplexer between the 8-bit pin-level application interface and the `CHANNELS`-wide streaming ports of `usb_cdc`. It replaces direct wiring, which can expose only one channel's byte bus. The IN direction (pins to USB) demultiplexes tagged bytes into per-channel FIFOs. The OUT direction (USB to pins) round-robin arbitrates the channels onto one registered, channel-tagged byte stream.

---
 rtl/usb_cdc_mux_pkg.sv | 8 +
 rtl/usb_cdc_byte_fifo.sv | 34 +++
 rtl/usb_cdc_chan_mux.sv | 87 ++++++++
 tb/tb_usb_cdc_chan_mux.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/usb_cdc_mux_pkg.sv
// usb_cdc_mux_pkg: shared types, limits and tag-width helper for the CDC channel mux
package usb_cdc_mux_pkg;
   localparam int MAX_CHANNELS = 8;
   typedef logic [7:0] byte_t;
   function automatic int chan_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/usb_cdc_byte_fifo.sv
// usb_cdc_byte_fifo: per-channel byte FIFO with wrap-bit pointers, head shows 0 when empty
module usb_cdc_byte_fifo
   import usb_cdc_mux_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push,
   input  logic  pop,
   input  byte_t din,
   output logic  full,
   output logic  empty,
   output byte_t head
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr, rd;
   byte_t mem [DEPTH];
   assign full  = (wr ^ rd) == {1'b1, {AW{1'b0}}};
   assign empty = wr == rd;
   assign head  = empty ? '0 : mem[rd[AW-1:0]];
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr <= '0;
         rd <= '0;
      end else begin
         if (push && !full) wr <= wr + 1'b1;
         if (pop && !empty) rd <= rd + 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (push && !full) mem[wr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/usb_cdc_chan_mux.sv
// usb_cdc_chan_mux: demuxes tagged pin bytes into per-channel FIFOs and round-robin muxes CDC channels onto one tagged stream
module usb_cdc_chan_mux
   import usb_cdc_mux_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 4,
   parameter int CW       = chan_w(CHANNELS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            pin_in_data_i,
   input  logic [CW-1:0]         pin_in_chan_i,
   input  logic                  pin_in_valid_i,
   output logic                  pin_in_ready_o,
   output logic [7:0]            pin_out_data_o,
   output logic [CW-1:0]         pin_out_chan_o,
   output logic                  pin_out_valid_o,
   input  logic                  pin_out_ready_i,
   output logic [8*CHANNELS-1:0] cdc_in_data_o,
   output logic [CHANNELS-1:0]   cdc_in_valid_o,
   input  logic [CHANNELS-1:0]   cdc_in_ready_i,
   input  logic [8*CHANNELS-1:0] cdc_out_data_i,
   input  logic [CHANNELS-1:0]   cdc_out_valid_i,
   output logic [CHANNELS-1:0]   cdc_out_ready_o,
   output logic                  drop_o
);
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_params
      $error("usb_cdc_chan_mux: DEPTH must be a power of two >= 2 and CHANNELS 1..MAX_CHANNELS");
   end
   logic [CHANNELS-1:0] full, empty, push;
   logic in_ok, load, gnt_ok;
   logic [CW-1:0] rr, g, c;
   int k;
   assign in_ok          = int'(pin_in_chan_i) < CHANNELS;
   assign pin_in_ready_o = in_ok ? !full[pin_in_chan_i] : 1'b1;
   assign cdc_in_valid_o = ~empty;
   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      assign push[n] = pin_in_valid_i && pin_in_chan_i == CW'(n) && !full[n];
      usb_cdc_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .push  (push[n]),
         .pop   (cdc_in_ready_i[n]),
         .din   (pin_in_data_i),
         .full  (full[n]),
         .empty (empty[n]),
         .head  (cdc_in_data_o[8*n +: 8])
      );
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) drop_o <= 1'b0;
      else if (pin_in_valid_i && !in_ok) drop_o <= 1'b1;
   end
   assign load = !pin_out_valid_o || pin_out_ready_i;
   // first requester at or after rr, wrapping at CHANNELS
   always_comb begin
      gnt_ok = 1'b0;
      g = '0;
      c = '0;
      k = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         k = int'(rr) + i;
         c = CW'(k >= CHANNELS ? k - CHANNELS : k);
         if (!gnt_ok && cdc_out_valid_i[c]) begin
            gnt_ok = 1'b1;
            g = c;
         end
      end
      cdc_out_ready_o = '0;
      if (gnt_ok && load) cdc_out_ready_o[g] = 1'b1;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr              <= '0;
         pin_out_valid_o <= 1'b0;
         pin_out_data_o  <= '0;
         pin_out_chan_o  <= '0;
      end else if (gnt_ok && load) begin
         rr              <= (int'(g) == CHANNELS - 1) ? '0 : g + 1'b1;
         pin_out_valid_o <= 1'b1;
         pin_out_data_o  <= cdc_out_data_i[{g, 3'b000} +: 8];
         pin_out_chan_o  <= g;
      end else if (pin_out_ready_i) begin
         pin_out_valid_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_usb_cdc_chan_mux.sv
// tb_usb_cdc_chan_mux: table-driven directed vectors plus reset sequences for a 3-channel, depth-4 mux
module tb_usb_cdc_chan_mux;
   localparam int CH = 3;
   localparam int DP = 4;
   localparam int CW = 2;
   logic clk = 1'b0;
   logic rst_i = 1'b1;
   logic [7:0] pin_in_data_i = '0;
   logic [CW-1:0] pin_in_chan_i = '0;
   logic pin_in_valid_i = 1'b0;
   logic pin_in_ready_o;
   logic [7:0] pin_out_data_o;
   logic [CW-1:0] pin_out_chan_o;
   logic pin_out_valid_o;
   logic pin_out_ready_i = 1'b1;
   logic [8*CH-1:0] cdc_in_data_o;
   logic [CH-1:0] cdc_in_valid_o;
   logic [CH-1:0] cdc_in_ready_i = '0;
   logic [8*CH-1:0] cdc_out_data_i = 24'hC2B1A0;
   logic [CH-1:0] cdc_out_valid_i = '0;
   logic [CH-1:0] cdc_out_ready_o;
   logic drop_o;
   always #5 clk = ~clk;
   usb_cdc_chan_mux #(.CHANNELS(CH), .DEPTH(DP)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .pin_in_data_i   (pin_in_data_i),
      .pin_in_chan_i   (pin_in_chan_i),
      .pin_in_valid_i  (pin_in_valid_i),
      .pin_in_ready_o  (pin_in_ready_o),
      .pin_out_data_o  (pin_out_data_o),
      .pin_out_chan_o  (pin_out_chan_o),
      .pin_out_valid_o (pin_out_valid_o),
      .pin_out_ready_i (pin_out_ready_i),
      .cdc_in_data_o   (cdc_in_data_o),
      .cdc_in_valid_o  (cdc_in_valid_o),
      .cdc_in_ready_i  (cdc_in_ready_i),
      .cdc_out_data_i  (cdc_out_data_i),
      .cdc_out_valid_i (cdc_out_valid_i),
      .cdc_out_ready_o (cdc_out_ready_o),
      .drop_o          (drop_o)
   );
   typedef struct {
      logic [7:0]  d;
      logic [1:0]  ch;
      logic        v;
      logic [2:0]  cir;
      logic [2:0]  cov;
      logic        por;
      logic        pir;
      logic [2:0]  civ;
      logic [23:0] cid;
      logic [2:0]  cor;
      logic        pov;
      logic [1:0]  poc;
      logic [7:0]  pod;
      logic        drop;
   } vec_t;
   vec_t tv[$];
   int n_chk = 0;
   int n_err = 0;
   function automatic vec_t mk(int d, int ch, int v, int cir, int cov, int por,
                               int pir, int civ, int cid, int cor, int pov, int poc, int pod, int drop);
      return '{8'(d), 2'(ch), 1'(v), 3'(cir), 3'(cov), 1'(por),
               1'(pir), 3'(civ), 24'(cid), 3'(cor), 1'(pov), 2'(poc), 8'(pod), 1'(drop)};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   initial begin
      // ch1 fill to DEPTH with the sink stalled, then drain in order
      tv.push_back(mk('h10,1,1,0,0,1, 1,0,'h000000,0,0,0,0,0));
      tv.push_back(mk('h11,1,1,0,0,1, 1,2,'h001000,0,0,0,0,0));
      tv.push_back(mk('h12,1,1,0,0,1, 1,2,'h001000,0,0,0,0,0));
      tv.push_back(mk('h13,1,1,0,0,1, 1,2,'h001000,0,0,0,0,0));
      tv.push_back(mk('h14,1,1,0,0,1, 0,2,'h001000,0,0,0,0,0));
      tv.push_back(mk('h14,1,1,2,0,1, 0,2,'h001000,0,0,0,0,0));
      tv.push_back(mk(0,0,0,2,0,1, 1,2,'h001100,0,0,0,0,0));
      tv.push_back(mk(0,0,0,2,0,1, 1,2,'h001200,0,0,0,0,0));
      tv.push_back(mk(0,0,0,2,0,1, 1,2,'h001300,0,0,0,0,0));
      tv.push_back(mk(0,0,0,2,0,1, 1,0,'h000000,0,0,0,0,0));
      // ch0 full, push refused during a pop, accepted next cycle
      tv.push_back(mk('h01,0,1,0,0,1, 1,0,'h000000,0,0,0,0,0));
      tv.push_back(mk('h02,0,1,0,0,1, 1,1,'h000001,0,0,0,0,0));
      tv.push_back(mk('h03,0,1,0,0,1, 1,1,'h000001,0,0,0,0,0));
      tv.push_back(mk('h04,0,1,0,0,1, 1,1,'h000001,0,0,0,0,0));
      tv.push_back(mk('h05,0,1,1,0,1, 0,1,'h000001,0,0,0,0,0));
      tv.push_back(mk('h05,0,1,0,0,1, 1,1,'h000002,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,0,1, 0,1,'h000002,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,0,1, 1,1,'h000003,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,0,1, 1,1,'h000004,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,0,1, 1,1,'h000005,0,0,0,0,0));
      tv.push_back(mk(0,0,0,1,0,1, 1,0,'h000000,0,0,0,0,0));
      // round-robin between ch0/ch1 at full rate
      tv.push_back(mk(0,0,0,0,3,1, 1,0,0,1,0,0,0,0));
      tv.push_back(mk(0,0,0,0,3,1, 1,0,0,2,1,0,'hA0,0));
      tv.push_back(mk(0,0,0,0,3,1, 1,0,0,1,1,1,'hB1,0));
      tv.push_back(mk(0,0,0,0,3,1, 1,0,0,2,1,0,'hA0,0));
      // backpressure holds the output register and blocks grants
      tv.push_back(mk(0,0,0,0,3,0, 1,0,0,0,1,1,'hB1,0));
      tv.push_back(mk(0,0,0,0,3,0, 1,0,0,0,1,1,'hB1,0));
      tv.push_back(mk(0,0,0,0,3,0, 1,0,0,0,1,1,'hB1,0));
      tv.push_back(mk(0,0,0,0,3,1, 1,0,0,1,1,1,'hB1,0));
      tv.push_back(mk(0,0,0,0,0,1, 1,0,0,0,1,0,'hA0,0));
      tv.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0,0,0,0));
      // search from rr=1 reaches ch2, then wraps to ch0
      tv.push_back(mk(0,0,0,0,4,1, 1,0,0,4,0,0,0,0));
      tv.push_back(mk(0,0,0,0,3,1, 1,0,0,1,1,2,'hC2,0));
      tv.push_back(mk(0,0,0,0,0,1, 1,0,0,0,1,0,'hA0,0));
      tv.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0,0,0,0));
      // out-of-range tag: accepted, dropped, sticky flag
      tv.push_back(mk('h55,3,1,0,0,1, 1,0,0,0,0,0,0,0));
      tv.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0,0,0,1));
      tv.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0,0,0,1));
      repeat (2) @(negedge clk);
      chk("rst.pov", 32'(pin_out_valid_o), 0);
      chk("rst.civ", 32'(cdc_in_valid_o), 0);
      chk("rst.drop", 32'(drop_o), 0);
      chk("rst.pir", 32'(pin_in_ready_o), 1);
      rst_i = 1'b0;
      for (int i = 0; i < tv.size(); i++) begin
         @(posedge clk);
         #1;
         pin_in_data_i   = tv[i].d;
         pin_in_chan_i   = tv[i].ch;
         pin_in_valid_i  = tv[i].v;
         cdc_in_ready_i  = tv[i].cir;
         cdc_out_valid_i = tv[i].cov;
         pin_out_ready_i = tv[i].por;
         @(negedge clk);
         chk($sformatf("v%0d.pir", i), 32'(pin_in_ready_o), 32'(tv[i].pir));
         chk($sformatf("v%0d.civ", i), 32'(cdc_in_valid_o), 32'(tv[i].civ));
         chk($sformatf("v%0d.cid", i), 32'(cdc_in_data_o), 32'(tv[i].cid));
         chk($sformatf("v%0d.cor", i), 32'(cdc_out_ready_o), 32'(tv[i].cor));
         chk($sformatf("v%0d.pov", i), 32'(pin_out_valid_o), 32'(tv[i].pov));
         chk($sformatf("v%0d.drop", i), 32'(drop_o), 32'(tv[i].drop));
         if (tv[i].pov) begin
            chk($sformatf("v%0d.poc", i), 32'(pin_out_chan_o), 32'(tv[i].poc));
            chk($sformatf("v%0d.pod", i), 32'(pin_out_data_o), 32'(tv[i].pod));
         end
      end
      // asynchronous reset mid-cycle with ch0 partly full and output valid
      @(posedge clk);
      #1;
      pin_in_data_i = 8'hAA; pin_in_chan_i = 2'd0; pin_in_valid_i = 1'b1;
      cdc_in_ready_i = '0; cdc_out_valid_i = 3'b001; pin_out_ready_i = 1'b0;
      @(posedge clk);
      #1;
      pin_in_data_i = 8'hBB; cdc_out_valid_i = '0;
      @(posedge clk);
      #1;
      pin_in_valid_i = 1'b0;
      @(negedge clk);
      chk("pre.pov", 32'(pin_out_valid_o), 1);
      chk("pre.pod", 32'(pin_out_data_o), 32'hA0);
      chk("pre.civ", 32'(cdc_in_valid_o), 1);
      chk("pre.drop", 32'(drop_o), 1);
      #2 rst_i = 1'b1;
      #1;
      chk("arst.pov", 32'(pin_out_valid_o), 0);
      chk("arst.pod", 32'(pin_out_data_o), 0);
      chk("arst.poc", 32'(pin_out_chan_o), 0);
      chk("arst.civ", 32'(cdc_in_valid_o), 0);
      chk("arst.cid", 32'(cdc_in_data_o), 0);
      chk("arst.drop", 32'(drop_o), 0);
      chk("arst.cor", 32'(cdc_out_ready_o), 0);
      @(posedge clk);
      #1;
      rst_i = 1'b0; pin_out_ready_i = 1'b1; cdc_out_valid_i = 3'b011;
      @(negedge clk);
      chk("post.pir", 32'(pin_in_ready_o), 1);
      chk("post.civ", 32'(cdc_in_valid_o), 0);
      chk("post.cor", 32'(cdc_out_ready_o), 32'b001);
      chk("post.drop", 32'(drop_o), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
